// File: rtl/dsp_add_acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_add_acc_pkg
//  Description : Shared types and helpers for the dsp_add_acc streaming
//                accumulator (FSM state encoding, effective-length helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package dsp_add_acc_pkg;

    // Group controller states, explicitly encoded in two bits.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the helper's argument. Beat-count fields up to this width are
    // supported by eff_len.
    localparam int c_LEN_BITS = 32;

    // A requested length of zero behaves exactly like a length of one.
    function automatic logic [c_LEN_BITS-1:0] eff_len(input logic [c_LEN_BITS-1:0] len);
        return (len == '0) ? {{(c_LEN_BITS-1){1'b0}}, 1'b1} : len;
    endfunction

endpackage : dsp_add_acc_pkg
`default_nettype wire

// File: rtl/dsp_add_acc_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_add_acc_cnt
//  Description : Beat counter for dsp_add_acc. Latches the effective group
//                length on the first beat, counts accepted beats and flags
//                the beat that completes the group.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clock        in   clock, all updates on posedge
//    reset        in   asynchronous active-high reset
//    i_load       in   first beat of a group accepted (cnt<=1, len_q<=eff len)
//    i_incr       in   further beat of a group accepted (cnt<=cnt+1)
//    i_len        in   requested group length, only used with i_load
//    o_cnt        out  beats accepted so far in this group
//    o_last_load  out  group completes on the loading beat (eff len == 1)
//    o_last_incr  out  group completes on the incrementing beat
// ============================================================================
module dsp_add_acc_cnt
    import dsp_add_acc_pkg::*;
#(
    parameter int COUNT_WIDTH = 8   // must not exceed c_LEN_BITS
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_load,
    input  logic                   i_incr,
    input  logic [COUNT_WIDTH-1:0] i_len,
    output logic [COUNT_WIDTH-1:0] o_cnt,
    output logic                   o_last_load,
    output logic                   o_last_incr
);

    logic [COUNT_WIDTH-1:0] r_cnt;
    logic [COUNT_WIDTH-1:0] r_len_q;
    logic [COUNT_WIDTH-1:0] w_eff;
    logic [COUNT_WIDTH:0]   w_cnt_next;

    assign w_eff = COUNT_WIDTH'(eff_len(c_LEN_BITS'(i_len)));

    // One extra bit so the terminal compare stays exact at the all-ones
    // length; cnt itself never passes len_q, so it never wraps.
    assign w_cnt_next = {1'b0, r_cnt} + {{COUNT_WIDTH{1'b0}}, 1'b1};

    assign o_last_load = (w_eff == {{(COUNT_WIDTH-1){1'b0}}, 1'b1});
    assign o_last_incr = (w_cnt_next == {1'b0, r_len_q});
    assign o_cnt       = r_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_len_q <= '0;
        end else if (i_load) begin
            r_cnt   <= {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            r_len_q <= w_eff;
        end else if (i_incr) begin
            r_cnt   <= w_cnt_next[COUNT_WIDTH-1:0];
        end
    end

endmodule : dsp_add_acc_cnt
`default_nettype wire

// File: rtl/dsp_add_acc.sv
`default_nettype none
// ============================================================================
//  Module      : dsp_add_acc
//  Description : Streaming accumulator for the dsp_add sum stream. Sums a
//                programmable number of beats modulo 2^WIDTH and presents
//                the result on a valid/ready port with a sticky unsigned
//                carry-out flag.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clock      in   clock, all updates on posedge
//    reset      in   asynchronous active-high reset
//    in_valid   in   input beat valid
//    in_ready   out  block can accept a beat (low only while a result waits)
//    in_data    in   beat value
//    len        in   beats in this group, sampled on the group's first beat
//    out_valid  out  result valid
//    out_ready  in   downstream accepts result
//    out_data   out  accumulated sum mod 2^WIDTH
//    out_ovf    out  at least one carry-out occurred in this group
//    out_count  out  number of beats summed
// ============================================================================
module dsp_add_acc
    import dsp_add_acc_pkg::*;
#(
    parameter int WIDTH       = 8,  // 1..48
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [COUNT_WIDTH-1:0] len,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_ovf,
    output logic [COUNT_WIDTH-1:0] out_count
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [WIDTH-1:0]       r_acc;
    logic                   r_ovf;
    logic [WIDTH:0]         w_sum;
    logic                   w_in_fire;
    logic                   w_out_fire;
    logic                   w_load;
    logic                   w_incr;
    logic [COUNT_WIDTH-1:0] w_cnt;
    logic                   w_last_load;
    logic                   w_last_incr;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_load     = (r_state == IDLE) & w_in_fire;
    assign w_incr     = (r_state == ACC) & w_in_fire;

    dsp_add_acc_cnt #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_cnt (
        .clock       (clock),
        .reset       (reset),
        .i_load      (w_load),
        .i_incr      (w_incr),
        .i_len       (len),
        .o_cnt       (w_cnt),
        .o_last_load (w_last_load),
        .o_last_incr (w_last_incr)
    );

    // Adder: the extra top bit is the carry-out of this beat.
    assign w_sum = {1'b0, r_acc} + {1'b0, in_data};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_load) begin
            r_acc <= in_data;
            r_ovf <= 1'b0;
        end else if (w_incr) begin
            r_acc <= w_sum[WIDTH-1:0];
            r_ovf <= r_ovf | w_sum[WIDTH];
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_in_fire) begin
                    w_state_next = w_last_load ? DONE : ACC;
                end
            end
            ACC: begin
                if (w_in_fire && w_last_incr) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (w_out_fire) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Output logic: the result port is zero except while a result is held,
    // and the input is only stalled while that result waits.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        out_data  = '0;
        out_ovf   = 1'b0;
        out_count = '0;
        if (r_state == DONE) begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
            out_data  = r_acc;
            out_ovf   = r_ovf;
            out_count = w_cnt;
        end
    end

endmodule : dsp_add_acc
`default_nettype wire

// File: tb/tb_dsp_add_acc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dsp_add_acc
//  Description : Self-checking bench for dsp_add_acc. A group-level model
//                (full-precision sum of the accepted beats) is compared with
//                the 8-bit instance every cycle; directed literal checks pin
//                the model and cover a 32-bit instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_add_acc;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [7:0]  len;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_ovf;
    logic [7:0]  out_count;

    logic        v32;
    logic        rdy32;
    logic [31:0] d32;
    logic [7:0]  l32;
    logic        ov32;
    logic        ordy32;
    logic [31:0] od32;
    logic        oovf32;
    logic [7:0]  ocnt32;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clock = ~clock;

    dsp_add_acc #(.WIDTH(8), .COUNT_WIDTH(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .len       (len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    dsp_add_acc #(.WIDTH(32), .COUNT_WIDTH(8)) dut32 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (v32),
        .in_ready  (rdy32),
        .in_data   (d32),
        .len       (l32),
        .out_valid (ov32),
        .out_ready (ordy32),
        .out_data  (od32),
        .out_ovf   (oovf32),
        .out_count (ocnt32)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Group model: collects accepted beats, and when a group is complete
    // holds its result until the downstream takes it.
    // ------------------------------------------------------------------
    bit         m_pending;
    int         m_n;
    int         m_len;
    longint     m_sum;
    logic [7:0] m_res;
    bit         m_ovf;
    int         m_cnt;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_pending = 1'b0;
            m_n       = 0;
            m_len     = 0;
            m_sum     = 0;
            m_res     = '0;
            m_ovf     = 1'b0;
            m_cnt     = 0;
        end else if (m_pending) begin
            if (out_ready) m_pending = 1'b0;
        end else if (in_valid) begin
            if (m_n == 0) m_len = (len == 8'd0) ? 1 : int'(len);
            m_sum += longint'(in_data);
            m_n++;
            if (m_n == m_len) begin
                m_pending = 1'b1;
                m_res     = m_sum[7:0];
                m_ovf     = (m_sum > 255);
                m_cnt     = m_n;
                m_n       = 0;
                m_sum     = 0;
            end
        end
    end

    always @(negedge clock) begin
        chk("cmp_in_ready", in_ready, !m_pending);
        chk("cmp_out_valid", out_valid, m_pending);
        if (m_pending) begin
            chk("cmp_out_data", out_data, m_res);
            chk("cmp_out_ovf", out_ovf, m_ovf);
            chk("cmp_out_count", out_count, m_cnt[7:0]);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic [7:0] l);
        in_valid = 1'b1;
        in_data  = d;
        len      = l;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string name, input logic [7:0] d,
                                 input logic o, input logic [7:0] c);
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_data"},  out_data,  d);
        chk({name, "_ovf"},   out_ovf,   o);
        chk({name, "_count"}, out_count, c);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        len       = '0;
        out_ready = 1'b1;
        v32       = 1'b0;
        d32       = '0;
        l32       = '0;
        ordy32    = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data",  out_data,  8'h00);
        chk("rst_out_ovf",   out_ovf,   1'b0);
        chk("rst_out_count", out_count, 8'h00);
        chk("rst_in_ready",  in_ready,  1'b1);
        reset = 1'b0;
        tick();

        // 32-bit instance: 1 + ffff0001
        v32 = 1'b1; l32 = 8'd2; d32 = 32'd1;
        tick();
        d32 = 32'hffff0001;
        tick();
        v32 = 1'b0;
        chk("w32_valid", ov32,   1'b1);
        chk("w32_data",  od32,   32'hffff0002);
        chk("w32_ovf",   oovf32, 1'b0);
        chk("w32_count", ocnt32, 8'd2);
        tick();
        chk("w32_release", ov32, 1'b0);

        // len=3: FF,10,01 -> 0x10 with carry
        in_valid = 1'b1; len = 8'd3; in_data = 8'hFF;
        tick();
        in_data = 8'h10;
        tick();
        in_data = 8'h01;
        tick();
        in_valid = 1'b0;
        expect_result("g3", 8'h10, 1'b1, 8'd3);
        tick();
        chk("g3_idle_valid", out_valid, 1'b0);
        chk("g3_idle_ready", in_ready,  1'b1);

        // len=1 and len=0 behave identically
        beat(8'h7F, 8'd1);
        expect_result("len1", 8'h7F, 1'b0, 8'd1);
        tick();
        beat(8'h7F, 8'd0);
        expect_result("len0", 8'h7F, 1'b0, 8'd1);
        tick();

        // Backpressure with a pending next beat
        out_ready = 1'b0;
        beat(8'h03, 8'd2);
        beat(8'h04, 8'd2);
        in_valid = 1'b1; in_data = 8'h55; len = 8'd1;
        for (int i = 0; i < 3; i++) begin
            expect_result("bp_hold", 8'h07, 1'b0, 8'd2);
            chk("bp_in_ready", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_drop_valid", out_valid, 1'b0);
        chk("bp_drop_ready", in_ready,  1'b1);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        expect_result("bp_next", 8'h55, 1'b0, 8'd1);
        out_ready = 1'b1;
        tick();

        // Gaps mid-group and len changing after the first beat
        beat(8'h01, 8'd4);
        tick(); tick();
        beat(8'h02, 8'd1);
        tick(); tick();
        beat(8'h03, 8'd1);
        beat(8'h04, 8'd1);
        expect_result("gap", 8'h0A, 1'b0, 8'd4);
        tick();

        // Reset in the middle of a group
        beat(8'hAA, 8'd3);
        reset = 1'b1;
        #1;
        chk("rmid_valid", out_valid, 1'b0);
        chk("rmid_data",  out_data,  8'h00);
        chk("rmid_count", out_count, 8'h00);
        chk("rmid_ready", in_ready,  1'b1);
        tick();
        reset = 1'b0;
        tick();
        beat(8'h05, 8'd1);
        expect_result("rpost", 8'h05, 1'b0, 8'd1);
        tick();

        // Maximum length, without and with wrap-around
        in_valid = 1'b1; len = 8'd255; in_data = 8'h01;
        repeat (255) tick();
        in_valid = 1'b0;
        expect_result("max1", 8'hFF, 1'b0, 8'd255);
        tick();
        in_valid = 1'b1; len = 8'd255; in_data = 8'h02;
        repeat (255) tick();
        in_valid = 1'b0;
        expect_result("max2", 8'hFE, 1'b1, 8'd255);
        tick();

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_dsp_add_acc
`default_nettype wire

// File: doc/dsp_add_acc.md
Name: dsp_add_acc

Overview:
Streaming accumulator that sits directly downstream of dsp_add and consumes its sum stream. It sums a programmable number of width-bit beats, modulo 2^width, into one result. The result is presented on a valid/ready output with a sticky unsigned-overflow flag. It is used to reduce dsp_add outputs in reticle ultrascale prim chains and bench flows.

Parameters:
width, 8, data width of input beats and of the result (1..48)
count_width, 8, width of the beat-count field len

Ports:
clock  input  1  single clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
in_data  input  width  beat value (dsp_add y)
len  input  count_width  number of beats in this group; sampled only on the first beat of a group
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  width  accumulated sum mod 2^width
out_ovf  output  1  at least one unsigned carry-out occurred in this group
out_count  output  count_width  number of beats summed (equals effective len)

Behaviour:
- Reset (async assert, sync release to next posedge):
  - state=IDLE; acc=0, ovf=0, cnt=0, len_q=0.
  - out_valid=0, out_data=0, out_ovf=0, out_count=0.
  - in_ready=1 while in reset and afterwards, since in_ready=(state!=DONE).
- Handshakes: input fire = in_valid & in_ready; output fire = out_valid & out_ready. Data is held while valid is low-ready.
- States:
  - IDLE: on input fire, acc<=in_data, ovf<=0, cnt<=1, len_q<=max(len,1). Go to DONE if the effective len is 1, else ACC.
  - ACC: on input fire, {c,acc}<=acc+in_data (width+1 bit add), ovf<=ovf|c, cnt<=cnt+1. Go to DONE when cnt+1==len_q, else stay. No fire means hold everything.
  - DONE: in_ready=0, out_valid=1. out_data=acc, out_ovf=ovf, out_count=cnt, all stable until output fire. On output fire go to IDLE and out_valid drops the next cycle.
- Latency: out_valid rises on the cycle after the posedge that accepted the last beat. Minimum group turnaround is len+1 cycles, with no overlap between result and the next group's first beat.
- len=0 is treated as 1. Changes on len after the first beat are ignored.
- Arithmetic is unsigned wrap-around. Signed callers ignore out_ovf.
- Gaps in in_valid mid-group are allowed. cnt and acc hold during gaps.
- Reset mid-group or while in DONE discards the partial or pending result immediately (async). No output fire occurs.
- in_valid high while in DONE is not consumed. The beat stays pending upstream.
- cnt never exceeds len_q. At len=2^count_width-1, cnt reaches the maximum without wrapping.

Decomposition:
- Package dsp_add_acc_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACC, DONE} state_t
  - a function eff_len(len) returning max(len,1)
- One natural sub-module: dsp_add_acc_cnt, the beat counter with load/increment/terminal-compare (cnt, len_q, last flag).
- The adder stays inline.

Test Plan:
- width=8, len=3, beats 0xFF,0x10,0x01 back-to-back, out_ready=1 -> out_valid one cycle after the third beat; out_data=0x10, out_ovf=1, out_count=3; IDLE next cycle.
- width=8, len=1, beat 0x7F -> out_data=0x7F, out_ovf=0, out_count=1 on the next cycle; repeat with len=0 -> identical result.
- width=32, len=2, beats 32'd1, 32'hffff0001 -> out_data=32'hffff0002, out_ovf=0.
- Backpressure: complete a len=2 group (0x03,0x04) with out_ready=0 for 3 cycles -> out_valid=1 and out_data=0x07 stable; in_ready=0 throughout; a pending in_valid beat 0x55 is not consumed until the cycle after out_ready=1, then it starts a new group.
- Gaps and len change: len=4, beats 0x01,0x02 with 2-cycle in_valid gaps, len driven to 1 mid-group, then 0x03,0x04 -> out_data=0x0A, out_count=4.
- Reset mid-op: len=3, accept 0xAA, assert reset for one cycle -> all outputs 0 immediately, in_ready=1; a new len=1 beat 0x05 -> out_data=0x05, out_ovf=0.
